// File: rtl/md5_search_engine.sv
// Purpose : iterative MD5 brute-force search over consecutive ASCII-decimal candidates.
// Latency : 64/ROUNDS_PER_CYCLE+3 cycles per candidate; done 1+n*(64/R+3) cycles after the start edge.
// Backpressure: none; start is accepted only in IDLE, abort ends the search at the next edge.
// Ports   : clk, reset (sync, active-high); start/abort controls; base_msg/num_cand/target_hash
//           search setup; busy/done status; found/found_msg/tested results of the last search.
module md5_search_engine #(
  parameter int MSG_BYTES        = 8,
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter int CNT_W            = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [8*MSG_BYTES-1:0] base_msg,
  input  logic [CNT_W-1:0]       num_cand,
  input  logic [127:0]           target_hash,
  output logic                   busy,
  output logic                   done,
  output logic                   found,
  output logic [8*MSG_BYTES-1:0] found_msg,
  output logic [CNT_W-1:0]       tested
);

  localparam logic [5:0] LAST_RND = 6'(64 - ROUNDS_PER_CYCLE);

  localparam logic [31:0] K_TAB [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee, 32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be, 32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa, 32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed, 32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c, 32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05, 32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039, 32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1, 32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  // Shift amount indexed by {round group, round mod 4}.
  localparam logic [4:0] S_TAB [16] = '{
    5'd7, 5'd12, 5'd17, 5'd22, 5'd5, 5'd9, 5'd14, 5'd20,
    5'd4, 5'd11, 5'd16, 5'd23, 5'd6, 5'd10, 5'd15, 5'd21
  };

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ROUND, S_FINAL, S_CMP, S_DONE} state_t;

  function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] s);
    logic [63:0] t;
    t = {x, x} << s;
    return t[63:32];
  endfunction

  function automatic logic [31:0] bswap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  // One MD5 step; state packed as {a,b,c,d}, message words W[j] = w[32*j +: 32].
  function automatic logic [127:0] md5_step(input logic [127:0] abcd, input logic [5:0] i,
                                            input logic [511:0] w);
    logic [31:0] sa, sb, sc, sd, f, tmp;
    logic [3:0]  g;
    {sa, sb, sc, sd} = abcd;
    case (i[5:4])
      2'd0:    begin f = (sb & sc) | (~sb & sd); g = i[3:0];               end
      2'd1:    begin f = (sd & sb) | (~sd & sc); g = i[3:0] * 4'd5 + 4'd1; end
      2'd2:    begin f = sb ^ sc ^ sd;           g = i[3:0] * 4'd3 + 4'd5; end
      default: begin f = sc ^ (sb | ~sd);        g = i[3:0] * 4'd7;        end
    endcase
    tmp = sa + f + K_TAB[i] + w[32*g +: 32];
    return {sd, sb + rotl(tmp, S_TAB[{i[5:4], i[1:0]}]), sb, sc};
  endfunction

  state_t                 state, state_nxt;
  logic [5:0]             rnd;
  logic [31:0]            a, b, c, d;
  logic [127:0]           abcd_nxt;
  logic [511:0]           blk;
  logic [8*MSG_BYTES-1:0] cand, cand_inc;
  logic [CNT_W-1:0]       ncand;
  logic [127:0]           tgt;
  logic                   match, last_cand, inc_carry;

  // Padded single block: char k lands in byte k (little-endian words), 0x80 after the message.
  always_comb begin
    blk = '0;
    for (int k = 0; k < MSG_BYTES; k++)
      blk[8*k +: 8] = cand[8*(MSG_BYTES-1-k) +: 8];
    blk[8*MSG_BYTES +: 8] = 8'h80;
    blk[14*32 +: 32]      = 32'(8*MSG_BYTES);
  end

  always_comb begin
    abcd_nxt = {a, b, c, d};
    for (int r = 0; r < ROUNDS_PER_CYCLE; r++)
      abcd_nxt = md5_step(abcd_nxt, rnd + 6'(r), blk);
  end

  // Decimal increment starting from the last char (least significant byte).
  always_comb begin
    cand_inc  = cand;
    inc_carry = 1'b1;
    for (int p = 0; p < MSG_BYTES; p++) begin
      if (inc_carry) begin
        if (cand[8*p +: 8] == 8'h39) begin
          cand_inc[8*p +: 8] = 8'h30;
        end else begin
          cand_inc[8*p +: 8] = cand[8*p +: 8] + 8'd1;
          inc_carry          = 1'b0;
        end
      end
    end
  end

  // In CMP, a..d already hold the finalised A..D.
  assign match     = ({bswap(a), bswap(b), bswap(c), bswap(d)} == tgt);
  assign last_cand = ((tested + CNT_W'(1)) == ncand);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    case (state)
      S_IDLE:  if (start) state_nxt = (num_cand == '0) ? S_DONE : S_LOAD;
      S_LOAD:  state_nxt = abort ? S_DONE : S_ROUND;
      S_ROUND: state_nxt = abort ? S_DONE : ((rnd == LAST_RND) ? S_FINAL : S_ROUND);
      S_FINAL: state_nxt = abort ? S_DONE : S_CMP;
      S_CMP:   state_nxt = (match || abort || last_cand) ? S_DONE : S_LOAD;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      found     <= 1'b0;
      found_msg <= '0;
      tested    <= '0;
      rnd       <= '0;
      {a, b, c, d} <= '0;
      cand      <= '0;
      ncand     <= '0;
      tgt       <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          cand      <= base_msg;
          ncand     <= num_cand;
          tgt       <= target_hash;
          found     <= 1'b0;
          found_msg <= '0;
          tested    <= '0;
        end
        S_LOAD: begin
          a   <= 32'h67452301;
          b   <= 32'hefcdab89;
          c   <= 32'h98badcfe;
          d   <= 32'h10325476;
          rnd <= '0;
        end
        S_ROUND: begin
          {a, b, c, d} <= abcd_nxt;
          rnd          <= rnd + 6'(ROUNDS_PER_CYCLE);
        end
        S_FINAL: begin
          a <= a + 32'h67452301;
          b <= b + 32'hefcdab89;
          c <= c + 32'h98badcfe;
          d <= d + 32'h10325476;
        end
        S_CMP: begin
          tested <= tested + CNT_W'(1);
          if (match) begin
            found     <= 1'b1;
            found_msg <= cand;
          end else begin
            cand <= cand_inc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_md5_search_engine.sv
// Purpose : self-checking bench for md5_search_engine across four parameterisations.
// Latency : checks done timing in cycles after the start edge against a scoreboard entry.
// Backpressure: n/a; one search at a time, bounded waits on every done.
module tb_md5_search_engine;

  logic         clk;
  logic         reset;
  logic         abort;
  logic [63:0]  base;
  logic [31:0]  ncand;
  logic [127:0] tgt;
  logic [3:0]   start_v, busy_v, done_v, found_v;
  logic [31:0]  tested_v [4];
  logic [63:0]  fmsg_v [4];
  logic [63:0]  fm_a, fm_b;
  logic [23:0]  fm_c;
  logic [7:0]   fm_d;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic        found;
    logic [63:0] msg;
    logic [31:0] tested;
    int          cycles;
  } exp_t;

  exp_t sb[$];

  assign fmsg_v[0] = fm_a;
  assign fmsg_v[1] = fm_b;
  assign fmsg_v[2] = {40'd0, fm_c};
  assign fmsg_v[3] = {56'd0, fm_d};

  md5_search_engine #(.MSG_BYTES(8), .ROUNDS_PER_CYCLE(1), .CNT_W(32)) u_8r1 (
    .clk(clk), .reset(reset), .start(start_v[0]), .abort(abort), .base_msg(base),
    .num_cand(ncand), .target_hash(tgt), .busy(busy_v[0]), .done(done_v[0]),
    .found(found_v[0]), .found_msg(fm_a), .tested(tested_v[0]));

  md5_search_engine #(.MSG_BYTES(8), .ROUNDS_PER_CYCLE(4), .CNT_W(32)) u_8r4 (
    .clk(clk), .reset(reset), .start(start_v[1]), .abort(abort), .base_msg(base),
    .num_cand(ncand), .target_hash(tgt), .busy(busy_v[1]), .done(done_v[1]),
    .found(found_v[1]), .found_msg(fm_b), .tested(tested_v[1]));

  md5_search_engine #(.MSG_BYTES(3), .ROUNDS_PER_CYCLE(1), .CNT_W(32)) u_3r1 (
    .clk(clk), .reset(reset), .start(start_v[2]), .abort(abort), .base_msg(base[23:0]),
    .num_cand(ncand), .target_hash(tgt), .busy(busy_v[2]), .done(done_v[2]),
    .found(found_v[2]), .found_msg(fm_c), .tested(tested_v[2]));

  md5_search_engine #(.MSG_BYTES(1), .ROUNDS_PER_CYCLE(1), .CNT_W(32)) u_1r1 (
    .clk(clk), .reset(reset), .start(start_v[3]), .abort(abort), .base_msg(base[7:0]),
    .num_cand(ncand), .target_hash(tgt), .busy(busy_v[3]), .done(done_v[3]),
    .found(found_v[3]), .found_msg(fm_d), .tested(tested_v[3]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Launch one search on instance u, push its expectation, then wait for done and score it.
  // Inputs are scrambled right after the start edge so only latched values can give the right answer;
  // start is held one extra cycle to confirm it is ignored while busy / in DONE.
  task automatic run_case(input int u, input logic [63:0] b, input logic [31:0] n,
                          input logic [127:0] t, input logic ef, input logic [63:0] em,
                          input logic [31:0] et, input int ecyc, input int abort_at);
    exp_t e;
    int   cyc;
    bit   seen;
    @(negedge clk);
    base = b; ncand = n; tgt = t;
    start_v[u] = 1'b1;
    e.found = ef; e.msg = em; e.tested = et; e.cycles = ecyc;
    sb.push_back(e);
    @(posedge clk);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        base = ~b; tgt = ~t; ncand = 32'd1;
      end
      start_v[u] = (cyc <= 1);
      abort      = (cyc == abort_at);
      if (cyc == 5) check_eq($sformatf("busy_mid_u%0d", u), {127'd0, busy_v[u]}, 128'd1);
      if (done_v[u]) seen = 1'b1;
    end
    abort      = 1'b0;
    start_v[u] = 1'b0;
    check_eq($sformatf("done_seen_u%0d", u), {127'd0, seen}, 128'd1);
    e = sb.pop_front();
    check_eq($sformatf("found_u%0d", u),     {127'd0, found_v[u]}, {127'd0, e.found});
    check_eq($sformatf("found_msg_u%0d", u), {64'd0, fmsg_v[u]},   {64'd0, e.msg});
    check_eq($sformatf("tested_u%0d", u),    {96'd0, tested_v[u]}, {96'd0, e.tested});
    check_eq($sformatf("done_cycle_u%0d", u), 128'(cyc), 128'(e.cycles));
    @(negedge clk);
    check_eq($sformatf("done_pulse_u%0d", u), {127'd0, done_v[u]}, 128'd0);
    check_eq($sformatf("idle_after_u%0d", u), {127'd0, busy_v[u]}, 128'd0);
    check_eq($sformatf("found_hold_u%0d", u), {127'd0, found_v[u]}, {127'd0, e.found});
  endtask

  localparam logic [63:0]  MSG_BASE = 64'h3132333435363730; // "12345670"
  localparam logic [63:0]  MSG_HIT  = 64'h3132333435363738; // "12345678"
  localparam logic [127:0] H_HIT    = 128'h25d55ad283aa400af464c76d713c07ad;
  localparam logic [127:0] H_000    = 128'hc6f057b86584942e415435ffb1fa93d4;
  localparam logic [127:0] H_1      = 128'hc4ca4238a0b923820dcc509a6f75849b;

  initial begin
    int dcount;
    reset   = 1'b1;
    abort   = 1'b0;
    start_v = '0;
    base    = '0;
    ncand   = '0;
    tgt     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int u = 0; u < 4; u++) begin
      check_eq($sformatf("rst_busy_u%0d", u),   {127'd0, busy_v[u]},  128'd0);
      check_eq($sformatf("rst_done_u%0d", u),   {127'd0, done_v[u]},  128'd0);
      check_eq($sformatf("rst_found_u%0d", u),  {127'd0, found_v[u]}, 128'd0);
      check_eq($sformatf("rst_msg_u%0d", u),    {64'd0, fmsg_v[u]},   128'd0);
      check_eq($sformatf("rst_tested_u%0d", u), {96'd0, tested_v[u]}, 128'd0);
    end
    reset = 1'b0;

    // Match after 9 candidates, R=1 and R=4.
    run_case(0, MSG_BASE, 32'd20, H_HIT, 1'b1, MSG_HIT, 32'd9, 604, 0);
    run_case(1, MSG_BASE, 32'd20, H_HIT, 1'b1, MSG_HIT, 32'd9, 172, 0);
    // "998","999","000" wrap, match on the third.
    run_case(2, 64'h393938, 32'd3, H_000, 1'b1, 64'h303030, 32'd3, 202, 0);
    // "2".."6" never hits md5("1"): exhaustion.
    run_case(3, 64'h32, 32'd5, H_1, 1'b0, 64'd0, 32'd5, 336, 0);
    // Zero candidates.
    run_case(0, MSG_BASE, 32'd0, H_HIT, 1'b0, 64'd0, 32'd0, 1, 0);
    // Abort during ROUND of the second candidate (edge 101 lies inside its rounds).
    run_case(0, MSG_BASE, 32'd20, 128'd0, 1'b0, 64'd0, 32'd1, 102, 101);

    // Reset in the middle of the second candidate: silent stop, outputs cleared.
    @(negedge clk);
    base = MSG_BASE; ncand = 32'd20; tgt = H_HIT; start_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (100) @(negedge clk);
    check_eq("busy_before_reset", {127'd0, busy_v[0]}, 128'd1);
    check_eq("tested_before_reset", {96'd0, tested_v[0]}, 128'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_eq("reset_busy",   {127'd0, busy_v[0]},  128'd0);
    check_eq("reset_done",   {127'd0, done_v[0]},  128'd0);
    check_eq("reset_found",  {127'd0, found_v[0]}, 128'd0);
    check_eq("reset_tested", {96'd0, tested_v[0]}, 128'd0);
    check_eq("reset_msg",    {64'd0, fmsg_v[0]},   128'd0);
    dcount = 0;
    repeat (700) begin
      @(negedge clk);
      if (done_v[0]) dcount++;
    end
    check_eq("no_done_after_reset", 128'(dcount), 128'd0);

    run_case(0, MSG_BASE, 32'd20, H_HIT, 1'b1, MSG_HIT, 32'd9, 604, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
